// File: rtl/mem_stage_if.sv
// Data-memory bus between the MEM stage (master) and the data memory (slave).
interface mem_stage_if;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [31:0] dmem_wdata_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_rdata_i;
  logic        dmem_ack_i;

  modport master (
    output dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, dmem_be_o,
    input  dmem_rdata_i, dmem_ack_i
  );
  modport slave (
    input  dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, dmem_be_o,
    output dmem_rdata_i, dmem_ack_i
  );
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: drives the data-memory bus with wait-state/timeout handling,
// aligns load data and owns the MEM/WB register.
module mem_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        RegWrite_i,
  input  logic        MemToReg_i,
  input  logic [1:0]  MemRead_i,
  input  logic [1:0]  MemWrite_i,
  input  logic [31:0] ALUdata_i,
  input  logic [31:0] WriteData_i,
  input  logic [4:0]  RegAddr_i,
  mem_stage_if.master dmem,
  output logic        stall_o,
  output logic        err_o,
  output logic        RegWrite_o,
  output logic        MemToReg_o,
  output logic [31:0] MemData_o,
  output logic [31:0] ALUdata_o,
  output logic [4:0]  RegAddr_o
);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic {IDLE, BUSY} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          regwrite_q, regwrite_d, memtoreg_q, memtoreg_d;
  logic [31:0]   memdata_q, memdata_d, aludata_q, aludata_d;
  logic [4:0]    regaddr_q, regaddr_d;

  logic        is_rd, is_wr, illegal, mem_op, misal, op_ok, timeout;
  logic        req, stall, err, done;
  logic [1:0]  size;
  logic [3:0]  be;
  logic [31:0] wdata, shifted, load_data;

  always_comb begin
    is_rd   = |MemRead_i;
    is_wr   = |MemWrite_i;
    size    = is_rd ? MemRead_i : MemWrite_i;
    illegal = is_rd & is_wr;
    mem_op  = is_rd ^ is_wr;
    misal   = mem_op && ((size == 2'd2 && ALUdata_i[0]) ||
                         (size == 2'd3 && ALUdata_i[1:0] != 2'b00));
    op_ok   = mem_op && !misal;
    // The last allowed BUSY cycle aborts outright; an ack arriving there is not taken.
    timeout = (state_q == BUSY) && (cnt_q == CW'(TIMEOUT - 1));
    req     = op_ok && !timeout && !rst_i;
    done    = req && dmem.dmem_ack_i;
    stall   = req && !dmem.dmem_ack_i;
    err     = !rst_i && (((state_q == IDLE) && (illegal || misal)) || timeout);

    be    = 4'b0000;
    wdata = WriteData_i;
    case (size)
      2'd1: begin be = 4'b0001 << ALUdata_i[1:0]; wdata = {4{WriteData_i[7:0]}};  end
      2'd2: begin be = 4'b0011 << ALUdata_i[1:0]; wdata = {2{WriteData_i[15:0]}}; end
      2'd3: be = 4'b1111;
      default: ;
    endcase

    shifted = dmem.dmem_rdata_i >> {ALUdata_i[1:0], 3'b000};
    case (MemRead_i)
      2'd1:    load_data = {{24{shifted[7]}}, shifted[7:0]};
      2'd2:    load_data = {{16{shifted[15]}}, shifted[15:0]};
      default: load_data = dmem.dmem_rdata_i;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (stall) begin
        state_d = BUSY;
        cnt_d   = '0;
      end
      BUSY: if (timeout || dmem.dmem_ack_i || !op_ok) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // Stalls and faulted accesses both load a bubble; data fields hold.
  always_comb begin
    regwrite_d = 1'b0;
    memtoreg_d = 1'b0;
    memdata_d  = memdata_q;
    aludata_d  = aludata_q;
    regaddr_d  = regaddr_q;
    if (!stall && !err) begin
      regwrite_d = RegWrite_i;
      memtoreg_d = MemToReg_i;
      aludata_d  = ALUdata_i;
      regaddr_d  = RegAddr_i;
      if (done && is_rd) memdata_d = load_data;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      regwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      memdata_q  <= '0;
      aludata_q  <= '0;
      regaddr_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      regwrite_q <= regwrite_d;
      memtoreg_q <= memtoreg_d;
      memdata_q  <= memdata_d;
      aludata_q  <= aludata_d;
      regaddr_q  <= regaddr_d;
    end
  end

  assign dmem.dmem_req_o   = req;
  assign dmem.dmem_we_o    = is_wr;
  assign dmem.dmem_addr_o  = {ALUdata_i[31:2], 2'b00};
  assign dmem.dmem_wdata_o = wdata;
  assign dmem.dmem_be_o    = be;
  assign stall_o    = stall;
  assign err_o      = err;
  assign RegWrite_o = regwrite_q;
  assign MemToReg_o = memtoreg_q;
  assign MemData_o  = memdata_q;
  assign ALUdata_o  = aludata_q;
  assign RegAddr_o  = regaddr_q;
endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: MEM_Stage

Interface
REQ-001 SHALL provide parameter TIMEOUT, default 16, meaning the maximum number of BUSY cycles allowed before an access is aborted.
REQ-002 SHALL provide port clk_i  input  1  clock; all state SHALL update on its rising edge.
REQ-003 SHALL provide port rst_i  input  1  reset; one clock, reset is synchronous and active-high.
REQ-004 SHALL provide inputs RegWrite_i and MemToReg_i (1 bit each), the EX/MEM control bits.
REQ-005 SHALL provide inputs MemRead_i and MemWrite_i (2 bits each); encoding: 0 none, 1 byte, 2 halfword, 3 word.
REQ-006 SHALL provide inputs ALUdata_i (32, address or result), WriteData_i (32, store data) and RegAddr_i (5, write-back register).
REQ-007 SHALL provide outputs dmem_req_o (1), dmem_we_o (1), dmem_addr_o (32, word-aligned), dmem_wdata_o (32) and dmem_be_o (4, byte enables).
REQ-008 SHALL provide inputs dmem_rdata_i (32) and dmem_ack_i (1, one-cycle completion strobe).
REQ-009 SHALL provide output stall_o (1), which freezes the PC, IF/ID, ID/EX and EX/MEM registers.
REQ-010 SHALL provide output err_o (1), a one-cycle pulse on a misaligned, illegal or timed-out access.
REQ-011 SHALL provide the MEM/WB register outputs RegWrite_o (1), MemToReg_o (1), MemData_o (32), ALUdata_o (32) and RegAddr_o (5).

Function
REQ-012 A memory op SHALL be defined as exactly one of MemRead_i and MemWrite_i being nonzero.
REQ-013 If both MemRead_i and MemWrite_i are nonzero, the access SHALL be treated as illegal.
REQ-014 FSM states SHALL be IDLE and BUSY.
- IDLE->BUSY: legal op with dmem_req_o high and dmem_ack_i low.
- BUSY->IDLE: on dmem_ack_i, or on timeout.
REQ-015 dmem_req_o SHALL be high combinationally for a legal op in IDLE, and SHALL stay high throughout BUSY until ack or timeout.
REQ-016 Zero-wait ack (ack in the same cycle as the first req) SHALL complete the access without entering BUSY.
REQ-017 dmem_addr_o SHALL be {ALUdata_i[31:2],2'b00}; dmem_we_o SHALL be high for writes; all dmem outputs SHALL be stable while req is high.
REQ-018 dmem_be_o SHALL be little-endian:
- byte: 4'b0001<<addr[1:0]
- half: 4'b0011<<addr[1:0]
- word: 4'b1111
REQ-019 dmem_wdata_o SHALL place the byte or half store data replicated into every lane.
REQ-020 Misalignment SHALL be defined as a half access with addr[0]=1, or a word access with addr[1:0]!=0.
REQ-021 A misaligned or illegal access SHALL issue no req and no stall, SHALL pulse err_o, and SHALL load a bubble into MEM/WB.
REQ-022 stall_o SHALL equal (legal op) AND NOT dmem_ack_i, evaluated in both IDLE and BUSY.
REQ-023 A BUSY cycle counter SHALL reset on entry to BUSY.
REQ-024 When the counter reaches TIMEOUT-1 without ack, the FSM SHALL return to IDLE, pulse err_o, drop req and stall, and load a bubble into MEM/WB.
REQ-025 Load extraction SHALL select the lane by addr[1:0] and sign-extend byte and half loads to 32 bits; word loads SHALL pass unchanged.
REQ-026 MEM/WB update per cycle:
- stalled: bubble (RegWrite_o=0, MemToReg_o=0, other fields hold).
- otherwise: capture RegWrite_i, MemToReg_i, ALUdata_i, RegAddr_i, plus the extracted load data (reads) or the previous MemData_o (non-reads).
REQ-027 A non-memory op SHALL pass through in one cycle, with latency 1 clock from the EX/MEM inputs to the MEM/WB outputs.
REQ-028 A load with ack in cycle N SHALL present MemData_o in cycle N+1.
REQ-029 A late or spurious dmem_ack_i in IDLE with no op SHALL be ignored.

Reset
REQ-030 While rst_i is high at a clock edge, state SHALL become IDLE, the counter 0, and every registered output 0.
REQ-031 While rst_i is high, dmem_req_o, stall_o and err_o SHALL be forced to 0.
REQ-032 Reset asserted in BUSY SHALL abandon the access, and a later ack SHALL be ignored.

Verification
REQ-033 Word load, zero-wait: addr 0x10 with rdata 0xDEADBEEF and ack in the same cycle -> no stall, next cycle MemData_o=0xDEADBEEF, RegWrite_o=1.
REQ-034 Byte load with 3 wait cycles: addr 0x13, rdata 0x80FFFFFF -> stall_o high for 3 cycles, RegWrite_o=0 during the stall, then MemData_o=0xFFFFFF80.
REQ-035 Half store: addr 0x22, WriteData_i=0x1234 -> be=4'b1100, wdata=0x12341234, we=1, addr=0x20.
REQ-036 Misaligned word load at 0x21 -> req stays 0, err_o pulses once, next cycle RegWrite_o=0.
REQ-037 No ack with TIMEOUT=4 -> stall for 4 cycles, err_o pulses, FSM returns to IDLE, RegWrite_o=0.
REQ-038 rst_i pulsed in BUSY followed by ack -> all outputs 0, FSM IDLE, the ack ignored.
